ripple_carry_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 6 +
 rtl/ripple_carry_adder_if.sv | 27 ++
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 66 ++++++
 tb/tb_ripple_carry_adder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the generic datapath adder.
package adder_pkg;

  localparam int unsigned ADDER_W = 6;

endpackage : adder_pkg

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the ripple-carry adder; master drives operands, slave returns the result.
interface ripple_carry_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_W
);

  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             C_in;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             ovf;
  logic             out_valid;

  modport master (
    output X, Y, C_in, in_valid,
    input  S, C_out, ovf, out_valid
  );

  modport slave (
    input  X, Y, C_in, in_valid,
    output S, C_out, ovf, out_valid
  );

endinterface : ripple_carry_adder_if

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full-adder cell used as one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p_c;

  assign p_c  = a ^ b;
  assign s    = p_c ^ cin;
  assign cout = (a & b) | (cin & p_c);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with registered sum, carry, signed overflow and valid (1-cycle latency).
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ripple_carry_adder_if.slave  bus
);

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_out_d, c_out_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign carry_c[0] = bus.C_in;

  // Carry ripples strictly LSB to MSB through one cell per bit.
  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_fa
    full_adder u_fa (
      .a    (bus.X[gi]),
      .b    (bus.Y[gi]),
      .cin  (carry_c[gi]),
      .s    (sum_c[gi]),
      .cout (carry_c[gi+1])
    );
  end

  // Operands are ignored entirely when not valid, so X/Z on idle inputs cannot leak into the result.
  always_comb begin
    s_d         = s_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d         = sum_c;
      c_out_d     = carry_c[WIDTH];
      ovf_d       = carry_c[WIDTH] ^ carry_c[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.C_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at widths 6 (default), 16 and 1.
module tb_ripple_carry_adder;

  localparam int unsigned W6 = adder_pkg::ADDER_W;

  typedef struct {
    logic [16:0] sum;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t q6[$];
  exp_t q16[$];
  exp_t q1[$];
  exp_t last6, last16, last1;

  ripple_carry_adder_if #(.WIDTH(W6)) bus6 ();
  ripple_carry_adder_if #(.WIDTH(16)) bus16 ();
  ripple_carry_adder_if #(.WIDTH(1))  bus1 ();

  ripple_carry_adder #(.WIDTH(W6)) u_dut6  (.clk(clk), .rst_n(rst_n), .bus(bus6));
  ripple_carry_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  ripple_carry_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer sum; signed overflow = same-sign operands giving a different-sign result.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic cin);
    exp_t e;
    e.sum = 17'(x) + 17'(y) + 17'(cin);
    e.ovf = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
    e.due = cyc + 1;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.sum = '0;
    e.ovf = 1'b0;
    e.due = 0;
    return e;
  endfunction

  // Monitors: a due entry must appear as a valid result; otherwise out_valid=0 and outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid6", 32'(bus6.out_valid), 32'(0));
      check("rst_sum6", 32'({bus6.ovf, bus6.C_out, bus6.S}), 32'(0));
      last6 = zero_exp();
    end else if (q6.size() > 0 && q6[0].due == cyc) begin
      e = q6.pop_front();
      check("valid6", 32'(bus6.out_valid), 32'(1));
      check("sum6", 32'({bus6.C_out, bus6.S}), 32'(e.sum));
      check("ovf6", 32'(bus6.ovf), 32'(e.ovf));
      last6 = e;
    end else begin
      check("idle_valid6", 32'(bus6.out_valid), 32'(0));
      check("hold6", 32'({bus6.ovf, bus6.C_out, bus6.S}), 32'({last6.ovf, last6.sum[6:0]}));
      if (q6.size() > 0 && q6[0].due < cyc) check("late6", 32'(q6[0].due), 32'(cyc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid16", 32'(bus16.out_valid), 32'(0));
      check("rst_sum16", 32'({bus16.ovf, bus16.C_out, bus16.S}), 32'(0));
      last16 = zero_exp();
    end else if (q16.size() > 0 && q16[0].due == cyc) begin
      e = q16.pop_front();
      check("valid16", 32'(bus16.out_valid), 32'(1));
      check("sum16", 32'({bus16.C_out, bus16.S}), 32'(e.sum));
      check("ovf16", 32'(bus16.ovf), 32'(e.ovf));
      last16 = e;
    end else begin
      check("idle_valid16", 32'(bus16.out_valid), 32'(0));
      check("hold16", 32'({bus16.ovf, bus16.C_out, bus16.S}), 32'({last16.ovf, last16.sum}));
      if (q16.size() > 0 && q16[0].due < cyc) check("late16", 32'(q16[0].due), 32'(cyc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid1", 32'(bus1.out_valid), 32'(0));
      check("rst_sum1", 32'({bus1.ovf, bus1.C_out, bus1.S}), 32'(0));
      last1 = zero_exp();
    end else if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      check("valid1", 32'(bus1.out_valid), 32'(1));
      check("sum1", 32'({bus1.C_out, bus1.S}), 32'(e.sum));
      check("ovf1", 32'(bus1.ovf), 32'(e.ovf));
      last1 = e;
    end else begin
      check("idle_valid1", 32'(bus1.out_valid), 32'(0));
      check("hold1", 32'({bus1.ovf, bus1.C_out, bus1.S}), 32'({last1.ovf, last1.sum[1:0]}));
      if (q1.size() > 0 && q1[0].due < cyc) check("late1", 32'(q1[0].due), 32'(cyc));
    end
  end

  task automatic apply6(input logic [5:0] x, input logic [5:0] y, input logic cin);
    @(posedge clk);
    #1;
    bus6.X = x; bus6.Y = y; bus6.C_in = cin; bus6.in_valid = 1'b1;
    bus16.in_valid = 1'b0; bus1.in_valid = 1'b0;
    q6.push_back(model(6, 16'(x), 16'(y), cin));
  endtask

  // Idle cycles with scrambled operands; results must not change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus6.in_valid = 1'b0;  bus6.X = 6'($urandom);   bus6.Y = 6'($urandom);
      bus16.in_valid = 1'b0; bus16.X = 16'($urandom); bus16.Y = 16'($urandom);
      bus1.in_valid = 1'b0;  bus1.X = 1'($urandom);   bus1.Y = 1'($urandom);
    end
  endtask

  task automatic apply_all();
    logic v6, v16, v1;
    @(posedge clk);
    #1;
    v6 = ($urandom_range(0, 3) != 0);
    v16 = ($urandom_range(0, 3) != 0);
    v1 = ($urandom_range(0, 3) != 0);
    bus6.X = 6'($urandom);   bus6.Y = 6'($urandom);   bus6.C_in = 1'($urandom);
    bus16.X = 16'($urandom); bus16.Y = 16'($urandom); bus16.C_in = 1'($urandom);
    bus1.X = 1'($urandom);   bus1.Y = 1'($urandom);   bus1.C_in = 1'($urandom);
    bus6.in_valid = v6; bus16.in_valid = v16; bus1.in_valid = v1;
    if (v6)  q6.push_back(model(6, 16'(bus6.X), 16'(bus6.Y), bus6.C_in));
    if (v16) q16.push_back(model(16, bus16.X, bus16.Y, bus16.C_in));
    if (v1)  q1.push_back(model(1, 16'(bus1.X), 16'(bus1.Y), bus1.C_in));
  endtask

  // Reset pulse between clock edges while a new operand is presented; it must be discarded.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    bus6.X = 6'd63; bus6.Y = 6'd63; bus6.C_in = 1'b1; bus6.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    bus6.in_valid = 1'b0;
    #1;
    check("async_clr_valid", 32'(bus6.out_valid), 32'(0));
    check("async_clr_sum", 32'({bus6.ovf, bus6.C_out, bus6.S}), 32'(0));
    q6.delete(); q16.delete(); q1.delete();
    last6 = zero_exp(); last16 = zero_exp(); last1 = zero_exp();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    last6 = zero_exp(); last16 = zero_exp(); last1 = zero_exp();
    rst_n = 1'b0;
    bus6.X = 6'h2A;    bus6.Y = 6'h15;    bus6.C_in = 1'b1;  bus6.in_valid = 1'b1;
    bus16.X = 16'hBEEF; bus16.Y = 16'h1234; bus16.C_in = 1'b1; bus16.in_valid = 1'b1;
    bus1.X = 1'b1;     bus1.Y = 1'b1;     bus1.C_in = 1'b1;  bus1.in_valid = 1'b1;
    #3;
    check("reset_valid", 32'(bus6.out_valid), 32'(0));
    check("reset_sum", 32'({bus6.ovf, bus6.C_out, bus6.S}), 32'(0));
    bus6.in_valid = 1'b0; bus16.in_valid = 1'b0; bus1.in_valid = 1'b0;
    #9;
    rst_n = 1'b1;

    apply6(6'd0, 6'd0, 1'b0);
    apply6(6'd4, 6'd5, 1'b1);
    apply6(6'd8, 6'd4, 1'b1);
    apply6(6'd63, 6'd1, 1'b0);
    apply6(6'd63, 6'd63, 1'b1);
    apply6(6'd31, 6'd1, 1'b0);
    idle(3);
    apply6(6'd32, 6'd32, 1'b0);
    mid_reset();
    idle(2);

    for (int i = 0; i < 8192; i++) begin
      logic [12:0] v;
      v = 13'(i);
      apply6(v[12:7], v[6:1], v[0]);
    end
    idle(2);

    for (int i = 0; i < 2000; i++) apply_all();
    idle(3);

    check("drain6", 32'(q6.size()), 32'(0));
    check("drain16", 32'(q16.size()), 32'(0));
    check("drain1", 32'(q1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ripple_carry_adder
